// File: rtl/fpu_link_pkg.sv
// Shared types and pin map for the FPU chip link master.
// Also holds a few fp16 constants used by benches.
package fpu_link_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CHIP_W   = 12;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NUM_NIBS = DATA_W / NIB_W;

    // chip pin map
    localparam int unsigned NIB_A_LSB     = 0;
    localparam int unsigned NIB_B_LSB     = 4;
    localparam int unsigned SEL_BIT       = 8;
    localparam int unsigned LOAD_BIT      = 9;
    localparam int unsigned OUT_VALID_BIT = 8;

    localparam logic [DATA_W-1:0] ONE   = 16'h3C00;
    localparam logic [DATA_W-1:0] TWO   = 16'h4000;
    localparam logic [DATA_W-1:0] THREE = 16'h4200;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CAP_HI,
        RESP
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              op;
    } fpu_req_t;

endpackage

// File: rtl/fpu_link_master_if.sv
// Request/response handshake plus the FPU chip pin bundle.
interface fpu_link_master_if;
    import fpu_link_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_timeout;
    logic [CHIP_W-1:0] chip_in;
    logic [CHIP_W-1:0] chip_out;

    modport master (
        input  req_valid, req_a, req_b, req_op, rsp_ready, chip_out,
        output req_ready, rsp_valid, rsp_result, rsp_timeout, chip_in
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, rsp_ready, chip_out,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout, chip_in
    );

endinterface

// File: rtl/fpu_link_nibble_mux.sv
// Picks the A/B operand nibbles for a given load cycle, LSB nibble first;
// cycles past the last nibble yield zero.
module fpu_link_nibble_mux
    import fpu_link_pkg::*;
#(
    parameter int unsigned IDX_W = 3
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IDX_W-1:0]  idx,
    output logic [NIB_W-1:0]  nib_a_c,
    output logic [NIB_W-1:0]  nib_b_c
);

    always_comb begin
        nib_a_c = '0;
        nib_b_c = '0;
        if (idx < IDX_W'(NUM_NIBS)) begin
            unique case (idx[1:0])
                2'd0: begin nib_a_c = a[3:0];   nib_b_c = b[3:0];   end
                2'd1: begin nib_a_c = a[7:4];   nib_b_c = b[7:4];   end
                2'd2: begin nib_a_c = a[11:8];  nib_b_c = b[11:8];  end
                2'd3: begin nib_a_c = a[15:12]; nib_b_c = b[15:12]; end
                default: begin nib_a_c = '0;    nib_b_c = '0;       end
            endcase
        end
    end

endmodule

// File: rtl/fpu_link_master.sv
// Host-side driver for the 16-bit FPU chip: serialises operands as nibbles,
// collects the two result bytes and returns one response (or a timeout).
module fpu_link_master
    import fpu_link_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 6,
    parameter int unsigned TIMEOUT     = 16
) (
    input logic               clock,
    input logic               reset,
    fpu_link_master_if.master bus
);

    localparam int unsigned LCNT_W = $clog2(LOAD_CYCLES);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);
    localparam logic [LCNT_W-1:0] LOAD_LAST    = LCNT_W'(LOAD_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT - 1);

    state_e            state_q,     state_d;
    fpu_req_t          req_q,       req_d;
    logic [LCNT_W-1:0] lcnt_q,      lcnt_d;
    logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic              timeout_q,   timeout_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CHIP_W-1:0] chip_in_q,   chip_in_d;
    logic [NIB_W-1:0]  nib_a_c,     nib_b_c;
    logic              unused_chip_bits;

    assign unused_chip_bits = ^bus.chip_out[CHIP_W-1:OUT_VALID_BIT+1];

    // Nibbles are looked up from next-cycle values so chip_in can be registered.
    fpu_link_nibble_mux #(.IDX_W(LCNT_W)) u_nibble_mux (
        .a       (req_d.a),
        .b       (req_d.b),
        .idx     (lcnt_d),
        .nib_a_c (nib_a_c),
        .nib_b_c (nib_b_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            lcnt_q      <= '0;
            tcnt_q      <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            chip_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            lcnt_q      <= lcnt_d;
            tcnt_q      <= tcnt_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            chip_in_q   <= chip_in_d;
        end
    end

    // Next state, datapath captures and registered handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        lcnt_d    = lcnt_q;
        tcnt_d    = tcnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d   = '{a: bus.req_a, b: bus.req_b, op: bus.req_op};
                    lcnt_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (lcnt_q == LOAD_LAST) begin
                    tcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            WAIT: begin
                // A valid flag on the final cycle still wins over the timeout.
                if (bus.chip_out[OUT_VALID_BIT]) begin
                    result_d[BYTE_W-1:0] = bus.chip_out[BYTE_W-1:0];
                    state_d              = CAP_HI;
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            CAP_HI: begin
                result_d[DATA_W-1:BYTE_W] = bus.chip_out[BYTE_W-1:0];
                timeout_d                 = 1'b0;
                state_d                   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // Chip pin image for the upcoming cycle; op select stays up until the response is taken.
    always_comb begin
        chip_in_d = '0;
        if (state_d == LOAD) begin
            chip_in_d[LOAD_BIT]                 = 1'b1;
            chip_in_d[SEL_BIT]                  = req_d.op;
            chip_in_d[NIB_A_LSB +: NIB_W]       = nib_a_c;
            chip_in_d[NIB_B_LSB +: NIB_W]       = nib_b_c;
        end else if (state_d != IDLE) begin
            chip_in_d[SEL_BIT] = req_d.op;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_timeout = timeout_q;
    assign bus.chip_in     = chip_in_q;

endmodule
